// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I control constants and types for the ID-stage pipeline sequencer.
package rv_ctrl_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_SRAI = 3'b101;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_SW   = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_ISH  = 3'd2,
      IMM_S    = 3'd3,
      IMM_B    = 3'd4
   } imm_sel_e;

   typedef struct packed {
      logic     uses_rs1;
      logic     uses_rs2;
      logic     writes_rd;
      logic     is_lw;
      logic     is_beq;
      imm_sel_e imm_sel;
   } dec_t;

   // Destination tracking for one downstream stage (EX or MEM).
   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic             wr;
      logic             ld;
   } stage_t;

   function automatic logic hit(input logic [REG_W-1:0] prd, input logic pwr, input dec_t d,
                                input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2);
      return pwr && ((d.uses_rs1 && (prd == s1)) || (d.uses_rs2 && (prd == s2)));
   endfunction

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// ID-stage instruction/branch inputs and pipeline control outputs of the sequencer.
interface hazard_flush_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             id_valid_i;
   logic [31:0]      id_instr_i;
   logic             br_eq_i;
   logic             pc_write_o;
   logic             if_id_write_o;
   logic             bubble_o;
   logic             flush_o;
   logic             pc_src_o;
   logic [2:0]       imm_sel_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output id_valid_i, id_instr_i, br_eq_i,
      input  pc_write_o, if_id_write_o, bubble_o, flush_o, pc_src_o, imm_sel_o,
             stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  id_valid_i, id_instr_i, br_eq_i,
      output pc_write_o, if_id_write_o, bubble_o, flush_o, pc_src_o, imm_sel_o,
             stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/id_decode_lite.sv
// Minimal opcode/funct3 classifier for the supported RV32I subset.
module id_decode_lite
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   output dec_t       dec
);

   always_comb begin
      dec         = dec_t'('0);
      dec.imm_sel = IMM_NONE;
      case (opcode)
         OP_IMM: begin
            if (funct3 == F3_ADDI) begin
               dec.uses_rs1  = 1'b1;
               dec.writes_rd = 1'b1;
               dec.imm_sel   = IMM_I;
            end else if (funct3 == F3_SRAI) begin
               dec.uses_rs1  = 1'b1;
               dec.writes_rd = 1'b1;
               dec.imm_sel   = IMM_ISH;
            end
         end
         OP_LOAD: begin
            if (funct3 == F3_LW) begin
               dec.uses_rs1  = 1'b1;
               dec.writes_rd = 1'b1;
               dec.is_lw     = 1'b1;
               dec.imm_sel   = IMM_I;
            end
         end
         OP_STORE: begin
            if (funct3 == F3_SW) begin
               dec.uses_rs1 = 1'b1;
               dec.uses_rs2 = 1'b1;
               dec.imm_sel  = IMM_S;
            end
         end
         OP_BRANCH: begin
            if (funct3 == F3_BEQ) begin
               dec.uses_rs1 = 1'b1;
               dec.uses_rs2 = 1'b1;
               dec.is_beq   = 1'b1;
               dec.imm_sel  = IMM_B;
            end
         end
         OP_REG: begin
            dec.uses_rs1  = 1'b1;
            dec.uses_rs2  = 1'b1;
            dec.writes_rd = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// ID-stage hazard/flush sequencer: load-use and branch-operand stalls, beq flush,
// EX/MEM destination shadows and saturating stall/flush counters.
module hazard_flush_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input logic              clk_i,
   input logic              rst_i,
   hazard_flush_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [REG_W-1:0] rs1;
   logic [REG_W-1:0] rs2;
   logic [REG_W-1:0] rd;
   dec_t             dec;
   stage_t           ex_q;
   stage_t           mem_q;
   stage_t           ex_d;
   logic             writes_c;
   logic             stall_c;
   logic             take_c;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;
   logic             unused_instr_hi;

   assign rs1             = bus.id_instr_i[19:15];
   assign rs2             = bus.id_instr_i[24:20];
   assign rd              = bus.id_instr_i[11:7];
   assign unused_instr_hi = ^bus.id_instr_i[31:25];

   id_decode_lite u_decode (
      .opcode (bus.id_instr_i[6:0]),
      .funct3 (bus.id_instr_i[14:12]),
      .dec    (dec)
   );

   // beq compares in ID with no forwarding, so it also waits on any EX writer and a MEM load.
   always_comb begin
      writes_c = dec.writes_rd && (rd != '0);
      ex_d     = '{rd: rd, wr: writes_c, ld: dec.is_lw && writes_c};
      stall_c  = 1'b0;
      if (dec.is_beq) begin
         stall_c = hit(ex_q.rd, ex_q.wr, dec, rs1, rs2) || hit(mem_q.rd, mem_q.ld, dec, rs1, rs2);
      end else begin
         stall_c = hit(ex_q.rd, ex_q.ld, dec, rs1, rs2);
      end
      stall_c = stall_c && bus.id_valid_i && !rst_i;
      take_c  = bus.id_valid_i && dec.is_beq && !stall_c && bus.br_eq_i;
   end

   assign bus.pc_write_o    = !stall_c;
   assign bus.if_id_write_o = !stall_c;
   assign bus.bubble_o      = stall_c;
   assign bus.flush_o       = take_c;
   assign bus.pc_src_o      = take_c;
   assign bus.imm_sel_o     = 3'(dec.imm_sel);
   assign bus.stall_cnt_o   = stall_cnt_q;
   assign bus.flush_cnt_o   = flush_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q        <= '0;
         mem_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         mem_q <= ex_q;
         ex_q  <= (bus.id_valid_i && !stall_c) ? ex_d : '0;
         if (stall_c && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (take_c && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed plus randomized check of hazard_flush_ctrl (32-bit and 4-bit counter builds)
// against an instruction-level model of producers still in flight.
module tb_hazard_flush_ctrl;

   typedef enum int {K_NOP, K_ADDI, K_SRAI, K_LW, K_SW, K_BEQ, K_R} kind_e;
   typedef struct {int dst; bit load;} prod_t;

   logic        clk = 1'b0;
   logic        rst_r;
   logic        valid;
   logic [31:0] instr;
   logic        br_eq;

   int    total = 0;
   int    bad   = 0;
   prod_t inflight [2];   // [0] one instruction ahead, [1] two ahead
   int    m_stall;
   int    m_flush;

   always #5 clk = ~clk;

   hazard_flush_ctrl_if #(.CNT_W(32)) if32 ();
   hazard_flush_ctrl_if #(.CNT_W(4))  if4 ();

   assign if32.id_valid_i = valid;
   assign if32.id_instr_i = instr;
   assign if32.br_eq_i    = br_eq;
   assign if4.id_valid_i  = valid;
   assign if4.id_instr_i  = instr;
   assign if4.br_eq_i     = br_eq;

   hazard_flush_ctrl #(.CNT_W(32)) u_dut32 (.clk_i(clk), .rst_i(rst_r), .bus(if32.slave));
   hazard_flush_ctrl #(.CNT_W(4))  u_dut4  (.clk_i(clk), .rst_i(rst_r), .bus(if4.slave));

   function automatic logic [31:0] i_lw(input int rd, input int rs1);
      return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
   endfunction
   function automatic logic [31:0] i_sw(input int rs2, input int rs1);
      return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd4, 7'b0100011};
   endfunction
   function automatic logic [31:0] i_add(input int rd, input int rs1, input int rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
   endfunction
   function automatic logic [31:0] i_addi(input int rd, input int rs1, input int imm);
      return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
   endfunction
   function automatic logic [31:0] i_srai(input int rd, input int rs1, input int sh);
      return {7'b0100000, 5'(sh), 5'(rs1), 3'b101, 5'(rd), 7'b0010011};
   endfunction
   function automatic logic [31:0] i_beq(input int rs1, input int rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'd8, 7'b1100011};
   endfunction

   function automatic kind_e classify(input logic [31:0] ins);
      logic [6:0] op;
      logic [2:0] f3;
      op = ins[6:0];
      f3 = ins[14:12];
      if (op == 7'h13 && f3 == 3'd0) return K_ADDI;
      if (op == 7'h13 && f3 == 3'd5) return K_SRAI;
      if (op == 7'h03 && f3 == 3'd2) return K_LW;
      if (op == 7'h23 && f3 == 3'd2) return K_SW;
      if (op == 7'h63 && f3 == 3'd0) return K_BEQ;
      if (op == 7'h33) return K_R;
      return K_NOP;
   endfunction

   function automatic bit reads(input int r, input bit u1, input bit u2, input int s1, input int s2);
      return (u1 && r == s1) || (u2 && r == s2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one instruction for one cycle, check everything, then advance the model.
   task automatic step(input logic v, input logic [31:0] ins, input logic br, input logic rst);
      kind_e k;
      bit    u1, u2, stall, take;
      int    s1, s2, dst, imm;
      valid = v;
      instr = ins;
      br_eq = br;
      rst_r = rst;
      #1;
      k   = classify(ins);
      u1  = (k != K_NOP);
      u2  = (k == K_SW) || (k == K_BEQ) || (k == K_R);
      s1  = int'(ins[19:15]);
      s2  = int'(ins[24:20]);
      dst = (k == K_ADDI || k == K_SRAI || k == K_LW || k == K_R) ? int'(ins[11:7]) : 0;
      case (k)
         K_ADDI, K_LW: imm = 1;
         K_SRAI:       imm = 2;
         K_SW:         imm = 3;
         K_BEQ:        imm = 4;
         default:      imm = 0;
      endcase
      stall = 1'b0;
      if (v && !rst) begin
         if (k == K_BEQ)
            stall = (inflight[0].dst != 0 && reads(inflight[0].dst, u1, u2, s1, s2)) ||
                    (inflight[1].load && reads(inflight[1].dst, u1, u2, s1, s2));
         else
            stall = inflight[0].load && reads(inflight[0].dst, u1, u2, s1, s2);
      end
      take = v && (k == K_BEQ) && !stall && br;

      chk("pc_write32",    32'(if32.pc_write_o),    32'(!stall));
      chk("if_id_write32", 32'(if32.if_id_write_o), 32'(!stall));
      chk("bubble32",      32'(if32.bubble_o),      32'(stall));
      chk("flush32",       32'(if32.flush_o),       32'(take));
      chk("pc_src32",      32'(if32.pc_src_o),      32'(take));
      chk("imm_sel32",     32'(if32.imm_sel_o),     32'(imm));
      chk("bubble4",       32'(if4.bubble_o),       32'(stall));
      chk("flush4",        32'(if4.flush_o),        32'(take));
      chk("stall_cnt32",   if32.stall_cnt_o,        32'(m_stall));
      chk("flush_cnt32",   if32.flush_cnt_o,        32'(m_flush));
      chk("stall_cnt4",    32'(if4.stall_cnt_o),    32'((m_stall > 15) ? 15 : m_stall));
      chk("flush_cnt4",    32'(if4.flush_cnt_o),    32'((m_flush > 15) ? 15 : m_flush));

      @(posedge clk);
      if (rst) begin
         inflight[0] = '{0, 1'b0};
         inflight[1] = '{0, 1'b0};
         m_stall     = 0;
         m_flush     = 0;
      end else begin
         inflight[1] = inflight[0];
         if (v && !stall) inflight[0] = '{dst, (k == K_LW) && dst != 0};
         else             inflight[0] = '{0, 1'b0};
         if (stall) m_stall++;
         if (take)  m_flush++;
      end
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, 32'h0000_0013, 1'b0, 1'b1);
      step(1'b0, 32'h0000_0013, 1'b0, 1'b1);
   endtask

   initial begin
      logic [31:0] ins;
      int          a, b, c;
      valid = 1'b0;
      instr = 32'h0000_0013;
      br_eq = 1'b0;
      rst_r = 1'b1;
      inflight[0] = '{0, 1'b0};
      inflight[1] = '{0, 1'b0};
      m_stall = 0;
      m_flush = 0;
      @(posedge clk);
      #1;

      // lw x5 -> add x6,x5,x2
      do_reset();
      step(1'b1, i_lw(5, 1), 1'b0, 1'b0);
      step(1'b1, i_add(6, 5, 2), 1'b0, 1'b0);
      step(1'b1, i_add(6, 5, 2), 1'b0, 1'b0);
      chk("lw_add_stalls", if32.stall_cnt_o, 32'd1);

      // lw x5 -> beq x5,x0 taken
      do_reset();
      step(1'b1, i_lw(5, 1), 1'b0, 1'b0);
      step(1'b1, i_beq(5, 0), 1'b1, 1'b0);
      step(1'b1, i_beq(5, 0), 1'b1, 1'b0);
      step(1'b1, i_beq(5, 0), 1'b1, 1'b0);
      chk("lw_beq_stalls", if32.stall_cnt_o, 32'd2);
      chk("lw_beq_flushes", if32.flush_cnt_o, 32'd1);

      // addi x7 -> beq x7,x8 not taken
      do_reset();
      step(1'b1, i_addi(7, 0, 3), 1'b0, 1'b0);
      step(1'b1, i_beq(7, 8), 1'b0, 1'b0);
      step(1'b1, i_beq(7, 8), 1'b0, 1'b0);
      chk("alu_beq_stalls", if32.stall_cnt_o, 32'd1);
      chk("alu_beq_flushes", if32.flush_cnt_o, 32'd0);

      // x0 destinations never stall
      do_reset();
      step(1'b1, i_addi(0, 0, 1), 1'b0, 1'b0);
      step(1'b1, i_add(6, 0, 0), 1'b0, 1'b0);
      step(1'b1, i_lw(0, 1), 1'b0, 1'b0);
      step(1'b1, i_beq(0, 0), 1'b0, 1'b0);
      step(1'b1, i_lw(9, 0), 1'b0, 1'b0);
      chk("x0_stalls", if32.stall_cnt_o, 32'd0);

      // lw x5 -> sw x5,4(x1)
      do_reset();
      step(1'b1, i_lw(5, 1), 1'b0, 1'b0);
      step(1'b1, i_sw(5, 1), 1'b0, 1'b0);
      step(1'b1, i_sw(5, 1), 1'b0, 1'b0);
      chk("lw_sw_stalls", if32.stall_cnt_o, 32'd1);

      // reset during the first lw->beq stall drops the hazard
      do_reset();
      step(1'b1, i_lw(5, 1), 1'b0, 1'b0);
      step(1'b1, i_beq(5, 0), 1'b1, 1'b1);
      chk("rst_stall_cnt", if32.stall_cnt_o, 32'd0);
      chk("rst_flush_cnt", if32.flush_cnt_o, 32'd0);
      step(1'b1, i_beq(5, 0), 1'b1, 1'b0);
      chk("rst_beq_nostall", if32.stall_cnt_o, 32'd0);
      chk("rst_beq_flush", if32.flush_cnt_o, 32'd1);

      // 20 load-use stalls saturate the 4-bit counter
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, i_lw(5, 1), 1'b0, 1'b0);
         step(1'b1, i_add(6, 5, 2), 1'b0, 1'b0);
         step(1'b1, i_add(6, 5, 2), 1'b0, 1'b0);
      end
      chk("sat_stall4", 32'(if4.stall_cnt_o), 32'd15);
      chk("sat_stall32", if32.stall_cnt_o, 32'd20);

      // randomized mix on a small register set to provoke hazards
      do_reset();
      for (int i = 0; i < 400; i++) begin
         a = int'($urandom_range(0, 3));
         b = int'($urandom_range(0, 3));
         c = int'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0: ins = i_lw(a, b);
            1: ins = i_sw(a, b);
            2: ins = i_add(a, b, c);
            3: ins = i_addi(a, b, c);
            4: ins = i_srai(a, b, c);
            5: ins = i_beq(a, b);
            6: ins = i_beq(a, b);
            default: ins = $urandom;
         endcase
         step(($urandom_range(0, 7) != 0), ins, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 49) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
